// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access stage: FSM state encoding,
// default error read value and the width of the optional timeout counter.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    // Wide enough for any practical TIMEOUT_CYCLES value (default 255).
    localparam int TMO_CNT_W = 16;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Counts BUSY cycles that pass without a memory acknowledge and flags the
// cycle in which the wait budget (LIMIT cycles) is used up.
module dmem_timeout_ctr
    import dmem_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(LIMIT - 1);

    logic [TMO_CNT_W-1:0] cnt_q;
    logic [TMO_CNT_W-1:0] cnt_d;

    // Next count: cleared outside BUSY, advanced on every un-acked BUSY cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en) begin
            cnt_d = cnt_q + TMO_CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The current un-acked cycle is the LIMIT-th one: give up after it.
    assign expired = count_en && (cnt_q == LAST);

endmodule

// File: rtl/dmem_access.sv
// Data-memory access stage of the pipeline. Turns a load/store held in the
// EX/MEM register into a single req/ack memory transaction, stalling the
// front of the pipeline until the transaction completes.
// Optional feature: define DMEM_TIMEOUT_EN to abandon a transaction after
// TIMEOUT_CYCLES un-acknowledged BUSY cycles (returns ERR_DATA on reads and
// sets the sticky timeout_err flag). Without it BUSY waits indefinitely.
module dmem_access
    import dmem_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [31:0] Addr_in,
    input  logic [31:0] WriteData_in,
    output logic [31:0] MemReadData_out,
    output logic        stall_out,
    output logic        misalign_out,
    output logic        timeout_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    dmem_state_e state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        we_q, we_d;

    logic req_any;
    logic access;
    logic tmo_expired;

    assign req_any = MemRead_in | MemWrite_in;
    assign access  = req_any & is_word_aligned(Addr_in);

`ifdef DMEM_TIMEOUT_EN
    logic tmo_err_q, tmo_err_d;

    dmem_timeout_ctr #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q != ST_BUSY),
        .count_en((state_q == ST_BUSY) && !mem_ack),
        .expired (tmo_expired)
    );

    // Sticky timeout flag: set when a transaction is abandoned, cleared only by reset.
    always_comb begin
        tmo_err_d = tmo_err_q | tmo_expired;
    end

    // Timeout flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_err_q <= 1'b0;
        end else begin
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_expired = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // FSM next state, request latching, read capture and handshake outputs.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        rdata_d      = rdata_q;
        stall_out    = 1'b0;
        misalign_out = 1'b0;
        mem_req      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    // A simultaneous read+write request is treated as a store.
                    addr_d    = Addr_in;
                    wdata_d   = WriteData_in;
                    we_d      = MemWrite_in;
                    state_d   = ST_BUSY;
                    stall_out = 1'b1;
                end else if (req_any) begin
                    misalign_out = 1'b1;
                end
            end
            ST_BUSY: begin
                mem_req   = 1'b1;
                stall_out = 1'b1;
                if (mem_ack) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                end else if (tmo_expired) begin
                    if (!we_q) begin
                        rdata_d = ERR_DATA;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Pipeline advances this cycle; the stale EX/MEM request must not restart.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // No stall or misalign indication while reset is being applied.
        if (rst) begin
            stall_out    = 1'b0;
            misalign_out = 1'b0;
        end
    end

    // State and latched-transaction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_we          = we_q;
    assign mem_addr        = addr_q;
    assign mem_wdata       = wdata_q;
    assign MemReadData_out = rdata_q;

endmodule

// File: tb/tb_dmem_access.sv
// Directed bench for dmem_access: table of load/store vectors applied
// back-to-back, plus hand-written reset, stray-ack and timeout sequences.
module tb_dmem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead_in, MemWrite_in;
    logic [31:0] Addr_in, WriteData_in;
    logic [31:0] MemReadData_out;
    logic        stall_out, misalign_out, timeout_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_access #(
        .TIMEOUT_CYCLES(4),
        .ERR_DATA      (32'hDEADBEEF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .MemRead_in     (MemRead_in),
        .MemWrite_in    (MemWrite_in),
        .Addr_in        (Addr_in),
        .WriteData_in   (WriteData_in),
        .MemReadData_out(MemReadData_out),
        .stall_out      (stall_out),
        .misalign_out   (misalign_out),
        .timeout_err    (timeout_err),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        int          exp_stall;
        int          exp_busy;
        int          exp_reqs;
        int          exp_mis;
        logic        exp_we;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", what, act, exp);
        end
    endtask

    // Present one instruction, act as memory (ack after v.waits wait states),
    // and measure stall/request/misalign behaviour until the pipeline advances.
    task automatic run_vec(input vec_t v, input int idx);
        int   stall_n, busy_n, rise_n, mis_n, cyc;
        logic prev_req, stable_ok, done;
        MemRead_in   = v.rd;
        MemWrite_in  = v.wr;
        Addr_in      = v.addr;
        WriteData_in = v.wdata;
        mem_rdata    = v.rdata;
        mem_ack      = 1'b0;
        stall_n = 0; busy_n = 0; rise_n = 0; mis_n = 0; cyc = 0;
        prev_req = 1'b0; stable_ok = 1'b1; done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (stall_out)    stall_n++;
            if (misalign_out) mis_n++;
            if (mem_req) begin
                busy_n++;
                if (!prev_req) rise_n++;
                if (mem_we !== v.exp_we || mem_addr !== v.addr || mem_wdata !== v.wdata)
                    stable_ok = 1'b0;
            end
            prev_req = mem_req;
            mem_ack  = mem_req && (busy_n == v.waits + 1);
            if (!stall_out) done = 1'b1;
        end
        check($sformatf("v%0d_completes", idx), 32'(done), 32'd1);
        check($sformatf("v%0d_stall_cycles", idx), stall_n, v.exp_stall);
        check($sformatf("v%0d_busy_cycles", idx), busy_n, v.exp_busy);
        check($sformatf("v%0d_mem_requests", idx), rise_n, v.exp_reqs);
        check($sformatf("v%0d_misalign_pulses", idx), mis_n, v.exp_mis);
        check($sformatf("v%0d_we_addr_wdata_stable", idx), 32'(stable_ok), 32'd1);
        check($sformatf("v%0d_read_data", idx), MemReadData_out, v.exp_out);
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   busy_n, cyc;
        logic done;

        vecs[0] = '{1'b1, 1'b0, 32'h10,       32'h0,        32'h12345678, 0, 2, 1, 1, 0, 1'b0, 32'h12345678};
        vecs[1] = '{1'b0, 1'b1, 32'h20,       32'hCAFEF00D, 32'h55555555, 3, 5, 4, 1, 0, 1'b1, 32'h12345678};
        vecs[2] = '{1'b1, 1'b0, 32'h22,       32'h0,        32'h0BADF00D, 0, 0, 0, 0, 1, 1'b0, 32'h12345678};
        vecs[3] = '{1'b1, 1'b0, 32'h0,        32'h0,        32'hA5A5A5A5, 0, 2, 1, 1, 0, 1'b0, 32'hA5A5A5A5};
        vecs[4] = '{1'b1, 1'b0, 32'h4,        32'h0,        32'h0F0F0F0F, 1, 3, 2, 1, 0, 1'b0, 32'h0F0F0F0F};
        vecs[5] = '{1'b1, 1'b1, 32'h8,        32'h11112222, 32'h99999999, 0, 2, 1, 1, 0, 1'b1, 32'h0F0F0F0F};
        vecs[6] = '{1'b0, 1'b1, 32'h31,       32'h44444444, 32'h0,        0, 0, 0, 0, 1, 1'b0, 32'h0F0F0F0F};
        vecs[7] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h80000001, 2, 4, 3, 1, 0, 1'b0, 32'h80000001};

        rst = 1'b1;
        MemRead_in = 1'b0; MemWrite_in = 1'b0;
        Addr_in = '0; WriteData_in = '0; mem_rdata = '0; mem_ack = 1'b0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_read_data", MemReadData_out, 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_stall", 32'(stall_out), 32'd0);
        check("rst_misalign", 32'(misalign_out), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_stall", 32'(stall_out), 32'd0);
        check("post_rst_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;

        // Table: back-to-back instructions, EX/MEM held while stalled
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end
        MemRead_in = 1'b0; MemWrite_in = 1'b0;

        // Stray ack with no request pending: no capture, no stall
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("idle_ack%0d_read_data", i), MemReadData_out, 32'h80000001);
            check($sformatf("idle_ack%0d_stall", i), 32'(stall_out), 32'd0);
            check($sformatf("idle_ack%0d_mem_req", i), 32'(mem_req), 32'd0);
        end
        @(posedge clk);
        #1 mem_ack = 1'b0;

        // Reset during the 2nd BUSY cycle, followed by a late ack
        MemRead_in = 1'b1; Addr_in = 32'h50; WriteData_in = 32'h13579BDF;
        mem_rdata = 32'h0BADBAD0;
        busy_n = 0; cyc = 0;
        while (busy_n < 2 && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (mem_req) busy_n++;
        end
        check("rstbusy_reached_busy2", busy_n, 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; MemRead_in = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        check("rstbusy_mem_req", 32'(mem_req), 32'd0);
        check("rstbusy_stall", 32'(stall_out), 32'd0);
        check("rstbusy_read_data", MemReadData_out, 32'h0);
        check("rstbusy_mem_we", 32'(mem_we), 32'd0);
        check("rstbusy_mem_addr", mem_addr, 32'h0);
        check("rstbusy_mem_wdata", mem_wdata, 32'h0);
        check("rstbusy_misalign", 32'(misalign_out), 32'd0);
        @(negedge clk);
        check("rstbusy_late_ack_read_data", MemReadData_out, 32'h0);
        check("rstbusy_late_ack_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1 mem_ack = 1'b0;

`ifdef DMEM_TIMEOUT_EN
        // Load that is never acknowledged: abandoned after 4 BUSY cycles
        MemRead_in = 1'b1; Addr_in = 32'h40; mem_rdata = 32'h11111111;
        busy_n = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (mem_req) busy_n++;
            if (!stall_out) done = 1'b1;
        end
        check("tmo_completes", 32'(done), 32'd1);
        check("tmo_busy_cycles", busy_n, 32'd4);
        check("tmo_mem_req_dropped", 32'(mem_req), 32'd0);
        check("tmo_read_data", MemReadData_out, 32'hDEADBEEF);
        check("tmo_err_set", 32'(timeout_err), 32'd1);
        @(posedge clk);
        #1 MemRead_in = 1'b0;
        repeat (3) @(negedge clk);
        check("tmo_err_sticky", 32'(timeout_err), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("tmo_err_cleared", 32'(timeout_err), 32'd0);
        check("tmo_read_data_cleared", MemReadData_out, 32'h0);
`else
        // Load that is not acknowledged for a long time: waits indefinitely
        MemRead_in = 1'b1; Addr_in = 32'h40; mem_rdata = 32'h11111111;
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) busy_n++;
        end
        check("wait_busy_cycles", busy_n, 32'd19);
        check("wait_still_stalled", 32'(stall_out), 32'd1);
        check("wait_timeout_err", 32'(timeout_err), 32'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("wait_done_stall", 32'(stall_out), 32'd0);
        check("wait_done_mem_req", 32'(mem_req), 32'd0);
        check("wait_read_data", MemReadData_out, 32'h11111111);
        @(posedge clk);
        #1 MemRead_in = 1'b0;
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
